// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared state encoding, ALU op codes and timeout default for the memory stage
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    localparam int ACK_TIMEOUT_DEFAULT = 255;

    // Word accesses only: the two low address bits must be zero.
    function automatic logic is_aligned(input logic [1:0] addr_lo);
        return addr_lo == 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-memory request/ack FSM with timeout and write-back bundle
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic [4:0]  rd,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_align,
    output logic        exc_bus
);

    // Counter holds 0..ACK_TIMEOUT-1 and stops at the last value, so it never wraps.
    localparam int               CNT_W    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e           state;
    logic [CNT_W-1:0] count;
    logic             is_load;
    logic             pend_reg_write;
    logic             timed_out;
    logic [31:0]      rdata_q;
    logic             is_mem;

    assign is_mem   = mem_read | mem_write;
    assign in_ready = (state == ST_IDLE);

    // Request/timeout FSM with all outputs registered; wb_valid and exceptions are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            count          <= '0;
            is_load        <= 1'b0;
            pend_reg_write <= 1'b0;
            timed_out      <= 1'b0;
            rdata_q        <= '0;
            dm_req         <= 1'b0;
            dm_we          <= 1'b0;
            dm_addr        <= '0;
            dm_wdata       <= '0;
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            exc_align      <= 1'b0;
            exc_bus        <= 1'b0;
        end else begin
            wb_valid  <= 1'b0;
            exc_align <= 1'b0;
            exc_bus   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        wb_rd <= rd;
                        if (!is_mem) begin
                            wb_valid     <= 1'b1;
                            wb_reg_write <= reg_write;
                            wb_data      <= alu_result;
                        end else if (!is_aligned(alu_result[1:0])) begin
                            wb_valid     <= 1'b1;
                            exc_align    <= 1'b1;
                            wb_reg_write <= 1'b0;
                            wb_data      <= alu_result;
                        end else begin
                            state          <= ST_ACCESS;
                            dm_req         <= 1'b1;
                            dm_we          <= mem_write;
                            dm_addr        <= alu_result;
                            dm_wdata       <= store_data;
                            count          <= '0;
                            // Read+write together is a store.
                            is_load        <= mem_read & ~mem_write;
                            pend_reg_write <= reg_write;
                            timed_out      <= 1'b0;
                            rdata_q        <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        dm_we  <= 1'b0;
                        if (is_load) begin
                            rdata_q <= dm_rdata;
                        end
                        state <= ST_DONE;
                    end else if (count == CNT_LAST) begin
                        dm_req    <= 1'b0;
                        dm_we     <= 1'b0;
                        timed_out <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    wb_valid     <= 1'b1;
                    exc_bus      <= timed_out;
                    wb_reg_write <= is_load & pend_reg_write & ~timed_out;
                    wb_data      <= is_load ? rdata_q : dm_addr;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a transaction-level reference model
module tb_mem_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        reg_write = 1'b0;
    logic [4:0]  rd = '0;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_align;
    logic        exc_bus;

    int n_cmp = 0;
    int n_err = 0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    mem_stage #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .store_data(store_data),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .rd(rd),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_align(exc_align), .exc_bus(exc_bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one instruction at a negedge with the DUT idle; ack_at is the ACCESS cycle (1-based)
    // in which the memory answers, and values above T mean no ack before the timeout.
    task automatic run_op(input logic mr, input logic mw, input logic rw, input logic [4:0] r,
                          input logic [31:0] a, input logic [31:0] sd, input int ack_at,
                          input logic [31:0] rdv);
        bit          is_mem;
        bit          is_ld;
        bit          ok_align;
        bit          acc;
        bit          exp_bus;
        bit          exp_rw;
        bit          chk_data;
        bit          seen;
        int          exp_lat;
        int          exp_req;
        int          lat;
        int          nreq;
        logic [31:0] exp_data;
        is_mem   = mr | mw;
        is_ld    = mr & ~mw;
        ok_align = (a[1:0] == 2'b00);
        acc      = is_mem && ok_align;
        exp_bus  = 1'b0;
        exp_data = a;
        seen     = 1'b0;
        lat      = 0;
        nreq     = 0;
        if (!is_mem) begin
            exp_lat = 1; exp_req = 0; exp_rw = rw; chk_data = 1'b1;
        end else if (!ok_align) begin
            exp_lat = 1; exp_req = 0; exp_rw = 1'b0; chk_data = 1'b0;
        end else if (ack_at <= T) begin
            exp_lat = ack_at + 2; exp_req = ack_at; exp_rw = is_ld & rw;
            chk_data = is_ld; exp_data = rdv;
        end else begin
            exp_lat = T + 2; exp_req = T; exp_rw = 1'b0; chk_data = 1'b0; exp_bus = 1'b1;
        end

        check("ready_at_issue", in_ready, 1);
        in_valid   = 1'b1;
        mem_read   = mr;
        mem_write  = mw;
        reg_write  = rw;
        rd         = r;
        alu_result = a;
        store_data = sd;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(negedge clk);
            in_valid   = 1'b0;
            dm_ack     = 1'b0;
            alu_result = $urandom;
            store_data = $urandom;
            check("in_ready", in_ready, (acc && cyc < exp_lat) ? 0 : 1);
            if (dm_req) begin
                nreq++;
                check("dm_addr", dm_addr, a);
                check("dm_we", dm_we, mw);
                check("dm_wdata", dm_wdata, sd);
            end
            if (wb_valid) begin
                seen = 1'b1;
                lat  = cyc;
            end else begin
                dm_rdata = $urandom;
                if (cyc == ack_at) begin
                    dm_ack   = 1'b1;
                    dm_rdata = rdv;
                end
            end
        end
        if (!seen) begin
            check("wb_never_seen", 0, 1);
        end
        check("latency", lat, exp_lat);
        check("dm_req_cycles", nreq, exp_req);
        check("wb_reg_write", wb_reg_write, exp_rw);
        check("exc_align", exc_align, is_mem && !ok_align);
        check("exc_bus", exc_bus, exp_bus);
        if (!(is_mem && !ok_align)) begin
            check("wb_rd", wb_rd, r);
        end
        if (chk_data) begin
            check("wb_data", wb_data, exp_data);
        end
        dm_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("wb_one_cycle", wb_valid, 0);
        check("exc_clear", {exc_align, exc_bus}, 0);
        dm_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dm_req", dm_req, 0);
        check("rst_dm_we", dm_we, 0);
        check("rst_dm_addr", dm_addr, 0);
        check("rst_dm_wdata", dm_wdata, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_reg_write", wb_reg_write, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_exc", {exc_align, exc_bus}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);

        run_op(1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0005, 32'h0, 1, 32'h0);
        run_op(1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0010, 32'h0, 2, 32'hDEAD_BEEF);
        run_op(1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0020, 32'h1234_5678, 1, 32'h0);
        run_op(1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0013, 32'h0, 1, 32'h0);
        run_op(1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0040, 32'h0, T + 1, 32'hCAFE_F00D);
        run_op(1'b1, 1'b1, 1'b1, 5'd6, 32'h0000_0044, 32'hAAAA_5555, 1, 32'h5555_AAAA);
        run_op(1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0048, 32'h0, 1, 32'h0BAD_CAFE);

        // Reset during the second wait cycle of a load abandons it.
        check("ready_pre_abort", in_ready, 1);
        in_valid   = 1'b1;
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        reg_write  = 1'b1;
        rd         = 5'd12;
        alu_result = 32'h0000_0080;
        @(negedge clk);
        in_valid = 1'b0;
        check("abort_req_c1", dm_req, 1);
        @(negedge clk);
        check("abort_req_c2", dm_req, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_req_dropped", dm_req, 0);
        check("abort_no_wb", wb_valid, 0);
        rst    = 1'b0;
        dm_ack = 1'b1;
        @(negedge clk);
        check("abort_ready", in_ready, 1);
        check("abort_late_ack", wb_valid, 0);
        dm_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_quiet", {wb_valid, dm_req}, 0);
        end

        for (int n = 0; n < 150; n++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                a[1:0] = 2'b00;
            end
            run_op(kind == 1 || kind == 3, kind == 2 || kind == 3, 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), a, $urandom, $urandom_range(1, T + 1), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
